// File: rtl/video_line_buffer.sv
// Double-buffered video line store between a pixel producer and video_sync.
//
// Package pocket supplies the pixel type shared with the rest of the video path.
//
// video_line_buffer ports:
//   clk, reset_n        sole clock, synchronous active-low reset
//   wr_valid/wr_ready   producer pixel handshake; wr_data pixel, wr_last ends a line
//   line_req            one-cycle pulse when a displayed bank is released
//   en                  video clock enable shared with video_sync
//   line_start          video_sync line-start pulse (qualified by en)
//   y_index_valid       current line is visible
//   x_index(_valid)     pixel index requested by video_sync
//   rgb_out             pixel for video_sync, one en-cycle after x_index
//   underflow           one-cycle pulse when a visible line had no full bank
//   underflow_count     saturating count of underflows

package pocket;
  typedef logic [23:0] rgb_t;
endpackage

module video_line_buffer #(
  parameter int unsigned LINE_WIDTH = 400,
  parameter int unsigned X_WIDTH    = $clog2(LINE_WIDTH),
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  pocket::rgb_t         wr_data,
  input  logic                 wr_last,
  output logic                 line_req,
  input  logic                 en,
  input  logic                 line_start,
  input  logic                 y_index_valid,
  input  logic [X_WIDTH-1:0]   x_index,
  input  logic                 x_index_valid,
  output pocket::rgb_t         rgb_out,
  output logic                 underflow,
  output logic [CNT_WIDTH-1:0] underflow_count
);

  // Length needs one extra bit so a full line of LINE_WIDTH always fits.
  localparam int unsigned LenW  = X_WIDTH + 1;
  localparam int unsigned Depth = 2 * LINE_WIDTH;
  localparam int unsigned AddrW = $clog2(Depth);

  typedef enum logic {StIdle, StShow} rd_state_e;

  pocket::rgb_t mem [Depth];

  logic [1:0]           full_q;
  logic [LenW-1:0]      len_q [2];
  logic                 wr_bank_q;
  logic [X_WIDTH-1:0]   wr_ptr_q;
  rd_state_e            rd_state_q;
  logic                 rd_bank_q;
  logic                 rd_valid_q;
  pocket::rgb_t         rd_data_q;
  logic                 line_req_q;
  logic                 underflow_q;
  logic [CNT_WIDTH-1:0] underflow_count_q;

  logic             wr_fire;
  logic             wr_end;
  logic             rd_hit;
  logic             next_bank;
  logic [AddrW-1:0] wr_addr;
  logic [AddrW-1:0] rd_addr;

  always_comb begin
    wr_ready  = ~full_q[wr_bank_q];
    wr_fire   = wr_valid & wr_ready;
    wr_end    = wr_last | (wr_ptr_q == X_WIDTH'(LINE_WIDTH - 1));
    wr_addr   = wr_bank_q ? AddrW'(LINE_WIDTH) + AddrW'(wr_ptr_q) : AddrW'(wr_ptr_q);
    // Checking against the bank length also rejects x_index >= LINE_WIDTH.
    rd_hit    = (rd_state_q == StShow) && x_index_valid &&
                (LenW'(x_index) < len_q[rd_bank_q]);
    rd_addr   = '0;
    if (rd_hit) begin
      rd_addr = rd_bank_q ? AddrW'(LINE_WIDTH) + AddrW'(x_index) : AddrW'(x_index);
    end
    next_bank = (rd_state_q == StShow) ? ~rd_bank_q : rd_bank_q;
  end

  // Plain one-write/one-read RAM; no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
    if (en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q            <= '0;
      len_q[0]          <= '0;
      len_q[1]          <= '0;
      wr_bank_q         <= 1'b0;
      wr_ptr_q          <= '0;
      rd_state_q        <= StIdle;
      rd_bank_q         <= 1'b0;
      rd_valid_q        <= 1'b0;
      line_req_q        <= 1'b0;
      underflow_q       <= 1'b0;
      underflow_count_q <= '0;
    end else begin
      line_req_q  <= 1'b0;
      underflow_q <= 1'b0;

      if (wr_fire) begin
        if (wr_end) begin
          full_q[wr_bank_q] <= 1'b1;
          len_q[wr_bank_q]  <= LenW'(wr_ptr_q) + LenW'(1);
          wr_bank_q         <= ~wr_bank_q;
          wr_ptr_q          <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_q + X_WIDTH'(1);
        end
      end

      if (en) begin
        rd_valid_q <= rd_hit;
      end

      // full_q is sampled pre-update, so a bank completing this cycle is not
      // yet visible. The released bank is never the bank being written.
      if (en && line_start) begin
        if (rd_state_q == StShow) begin
          full_q[rd_bank_q] <= 1'b0;
          line_req_q        <= 1'b1;
        end
        // Advance even on underflow so display order follows write order.
        rd_bank_q <= next_bank;
        if (y_index_valid && full_q[next_bank]) begin
          rd_state_q <= StShow;
        end else begin
          rd_state_q <= StIdle;
          if (y_index_valid) begin
            underflow_q <= 1'b1;
            if (underflow_count_q != '1) begin
              underflow_count_q <= underflow_count_q + CNT_WIDTH'(1);
            end
          end
        end
      end
    end
  end

  assign rgb_out         = rd_valid_q ? rd_data_q : '0;
  assign line_req        = line_req_q;
  assign underflow       = underflow_q;
  assign underflow_count = underflow_count_q;

endmodule
